// File: rtl/idct_pkg.sv
// -----------------------------------------------------------------------------
// idct_pkg
// Shared constants for the integer inverse DCT row pass:
//   - HEVC 4-point and 8-point integer basis tables, T[n][k] = basis n at
//     sample position k, stored as 8-bit signed values
//   - get_coef(): basis lookup selected by transform size
//   - rounding shift constants for the first and second pass
//   - FSM state encoding for the top level
// -----------------------------------------------------------------------------
package idct_pkg;

    localparam int SHIFT_PASS0      = 32'sd7;
    localparam int SHIFT_PASS1_BASE = 32'sd20;

    localparam logic signed [7:0] T4 [4][4] = '{
        '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83},
        '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36}
    };

    localparam logic signed [7:0] T8 [8][8] = '{
        '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{ 8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
        '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
        '{ 8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
        '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{ 8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
        '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
        '{ 8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Basis value of frequency n at position k for an n_size-point transform.
    function automatic logic signed [7:0] get_coef(input int n_size, input int n, input int k);
        logic signed [7:0] c;
        if (n_size == 32'sd8) begin
            c = T8[n[2:0]][k[2:0]];
        end else begin
            c = T4[n[1:0]][k[1:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/idct_row.sv
// -----------------------------------------------------------------------------
// idct_row
// Purely combinational N-point inverse transform of one coefficient row:
//   y_row[k] = clip16((sum_n T[n][k] * x_row[n] + 2^(S-1)) >>> S)
// Parameters: N (4 or 8), S (rounding shift).
// Ports:
//   x_row  in  16-bit signed x N : frequency coefficients
//   y_row  out 16-bit signed x N : spatial samples, rounded and saturated
// -----------------------------------------------------------------------------
module idct_row #(
    parameter int N = 4,
    parameter int S = 7
) (
    input  logic signed [15:0] x_row [N],
    output logic signed [15:0] y_row [N]
);
    import idct_pkg::*;

    localparam logic signed [31:0] RND = 32'sd1 <<< (S - 32'sd1);

    logic signed [31:0] acc_s [N];
    logic signed [31:0] shf_s [N];

    // Multiply-accumulate, round, floor-shift and saturate every output position.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            acc_s[k] = 32'sd0;
            for (int n = 0; n < N; n++) begin
                acc_s[k] = acc_s[k] + 32'(x_row[n]) * 32'(get_coef(N, n, k));
            end
            shf_s[k] = (acc_s[k] + RND) >>> S;
            if (shf_s[k] > 32'sd32767) begin
                y_row[k] = 16'sh7fff;
            end else if (shf_s[k] < -32'sd32768) begin
                y_row[k] = 16'sh8000;
            end else begin
                y_row[k] = shf_s[k][15:0];
            end
        end
    end

endmodule

// File: rtl/idct_1d.sv
// -----------------------------------------------------------------------------
// idct_1d
// Row pass of a separable integer inverse DCT. On an accepted start the whole
// N x N coefficient block is captured, then one row per clock is transformed
// into the registered output block; done pulses once after the last row.
// Parameters: N (4 or 8), BIT_DEPTH (second-pass shift), PASS (0 or 1).
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous, active-low reset
//   start  in  : run request, only honoured in IDLE
//   x      in  : 16-bit signed coefficients x[row][freq]
//   y      out : 16-bit signed registered samples y[row][pos]
//   done   out : one-cycle completion pulse, registered
// -----------------------------------------------------------------------------
module idct_1d #(
    parameter int N         = 4,
    parameter int BIT_DEPTH = 8,
    parameter int PASS      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] x [N][N],
    output logic signed [15:0] y [N][N],
    output logic               done
);
    import idct_pkg::*;

    if ((N != 32'sd4) && (N != 32'sd8)) begin : g_bad_n
        $error("idct_1d: N must be 4 or 8");
    end

    localparam int S  = (PASS == 32'sd0) ? SHIFT_PASS0 : (SHIFT_PASS1_BASE - BIT_DEPTH);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 32'sd1);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [RW-1:0]          row_r;
    logic signed [15:0]     x_cap_r [N][N];
    logic signed [15:0]     x_sel_s [N];
    logic signed [15:0]     y_row_s [N];
    logic                   cap_s;
    logic                   wr_s;
    logic                   fin_s;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (row_r == LAST_ROW) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        cap_s = 1'b0;
        wr_s  = 1'b0;
        fin_s = 1'b0;
        case (state_r)
            ST_IDLE: cap_s = start;
            ST_BUSY: wr_s  = 1'b1;
            ST_DONE: fin_s = 1'b1;
            default: begin
                cap_s = 1'b0;
                wr_s  = 1'b0;
                fin_s = 1'b0;
            end
        endcase
    end

    // Select the captured row currently being transformed.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            x_sel_s[n] = x_cap_r[row_r][n];
        end
    end

    idct_row #(.N(N), .S(S)) u_row (
        .x_row (x_sel_s),
        .y_row (y_row_s)
    );

    // Input capture, row counter, output block and the done pulse.
    // done is driven from the DONE state one edge later, so it is high exactly
    // while the complete block has been stable for at least one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done  <= 1'b0;
            row_r <= {RW{1'b0}};
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    x_cap_r[r][c] <= 16'sd0;
                    y[r][c]       <= 16'sd0;
                end
            end
        end else begin
            done <= fin_s;
            if (cap_s) begin
                row_r <= {RW{1'b0}};
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        x_cap_r[r][c] <= x[r][c];
                    end
                end
            end else if (wr_s) begin
                for (int c = 0; c < N; c++) begin
                    y[row_r][c] <= y_row_s[c];
                end
                if (row_r == LAST_ROW) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_idct_1d.sv
// -----------------------------------------------------------------------------
// tb_idct_1d
// Directed bench for idct_1d: a table of 4-point row-pass vectors with
// hand-computed results, plus sequences for reset, busy-start, input
// isolation, back-to-back runs, the second pass and the 8-point transform.
// -----------------------------------------------------------------------------
module tb_idct_1d;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic signed [15:0] x4 [4][4];
    logic signed [15:0] y0 [4][4];
    logic signed [15:0] y1 [4][4];
    logic signed [15:0] x8 [8][8];
    logic signed [15:0] y8 [8][8];
    logic done0, done1, done8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idct_1d #(.N(4), .BIT_DEPTH(8), .PASS(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .x(x4), .y(y0), .done(done0));
    idct_1d #(.N(4), .BIT_DEPTH(8), .PASS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .x(x4), .y(y1), .done(done1));
    idct_1d #(.N(8), .BIT_DEPTH(8), .PASS(0)) dut8 (
        .clk(clk), .reset(reset), .start(start), .x(x8), .y(y8), .done(done8));

    typedef logic [3:0][15:0] row4_t;
    typedef struct packed {
        row4_t x0;
        row4_t x1;
        row4_t e0;
        row4_t e1;
    } vec_t;

    vec_t vecs [4];

    function automatic row4_t mk4(input int a, input int b, input int c, input int d);
        row4_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_x();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) x4[r][c] = 16'sd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) x8[r][c] = 16'sd0;
    endtask

    task automatic load_vec(input vec_t v);
        clear_x();
        for (int k = 0; k < 4; k++) begin
            x4[0][k] = $signed(v.x0[k]);
            x4[1][k] = $signed(v.x1[k]);
        end
    endtask

    task automatic chk_row0(input string nm, input int r, input row4_t e);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_y[%0d][%0d]", nm, r, k), int'(y0[r][k]), int'($signed(e[k])));
    endtask

    function automatic int nonzero_y0();
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (y0[r][c] != 16'sd0) n++;
        return n;
    endfunction

    // Pulse start for one sampling edge; returns right after that edge (+1).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after the start-sampling edge until the chosen done is seen; -1 on timeout.
    task automatic wait_done(input int which, input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && done0) || (which == 1 && done1) || (which == 8 && done8)) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, ndone, first, second;
        row4_t zr, p1;

        reset = 1'b0;
        start = 1'b0;
        clear_x();
        zr = mk4(0, 0, 0, 0);

        vecs[0] = '{x0: mk4(1000, 0, 0, 0),           x1: zr,
                    e0: mk4(500, 500, 500, 500),      e1: zr};
        vecs[1] = '{x0: mk4(0, 1000, 0, 0),           x1: mk4(1000, 0, 0, 0),
                    e0: mk4(648, 281, -281, -648),    e1: mk4(500, 500, 500, 500)};
        vecs[2] = '{x0: mk4(32767, 32767, 0, 0),      x1: mk4(32767, 32767, 32767, 0),
                    e0: mk4(32767, 25599, 7168, -4864), e1: mk4(32767, 9216, -9216, 11520)};
        vecs[3] = '{x0: mk4(-32768, -32768, -32768, 0), x1: mk4(0, 0, 0, 1000),
                    e0: mk4(-32768, -9216, 9216, -11520), e1: mk4(281, -648, 648, -281)};

        // Reset state
        #12;
        chk("reset_nonzero_y", nonzero_y0(), 0);
        chk("reset_done", int'(done0), 0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven row-pass vectors
        for (int i = 0; i < 4; i++) begin
            load_vec(vecs[i]);
            pulse_start();
            wait_done(0, 20, lat);
            chk($sformatf("v%0d_done_latency", i), lat, 5);
            chk_row0($sformatf("v%0d", i), 0, vecs[i].e0);
            chk_row0($sformatf("v%0d", i), 1, vecs[i].e1);
            chk_row0($sformatf("v%0d", i), 2, zr);
            chk_row0($sformatf("v%0d", i), 3, zr);
            if (i == 0) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("pass1_y[0][%0d]", k), int'(y1[0][k]), 16);
                chk("pass1_done", int'(done1), 1);
            end
            if (i == 1) begin
                p1 = mk4(20, 9, -9, -20);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("pass1_ac_y[0][%0d]", k), int'(y1[0][k]), int'($signed(p1[k])));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_width", i), int'(done0), 0);
        end

        // 8-point transform: let the 8-point instance drain first
        repeat (12) @(posedge clk);
        clear_x();
        x8[0][1] = 16'sd1000;
        x8[1][0] = 16'sd1000;
        pulse_start();
        wait_done(8, 30, lat);
        chk("n8_done_latency", lat, 9);
        begin
            int e8 [8];
            e8 = '{695, 586, 391, 141, -141, -391, -586, -695};
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("n8_y[0][%0d]", k), int'(y8[0][k]), e8[k]);
                chk($sformatf("n8_y[1][%0d]", k), int'(y8[1][k]), 500);
                chk($sformatf("n8_y[7][%0d]", k), int'(y8[7][k]), 0);
            end
        end
        repeat (4) @(posedge clk);

        // Input isolation and start while busy
        load_vec(vecs[1]);
        pulse_start();
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) x4[r][c] = 16'sd7;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done0) ndone++;
        end
        chk("busy_start_done_count", ndone, 1);
        chk_row0("iso", 0, vecs[1].e0);
        chk_row0("iso", 1, vecs[1].e1);
        chk_row0("iso", 2, zr);

        // Start held high: back-to-back runs every N+2 cycles
        load_vec(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        first = -1;
        second = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                if (first < 0) begin
                    first = c;
                end else begin
                    second = c;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", first, 5);
        chk("b2b_second_done", second, 11);
        repeat (8) @(posedge clk);
        chk_row0("b2b", 0, vecs[0].e0);

        // Reset while idle clears the output block
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_reset_nonzero_y", nonzero_y0(), 0);
        chk("idle_reset_done", int'(done0), 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset while busy aborts the run
        load_vec(vecs[0]);
        pulse_start();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done0) ndone++;
        end
        chk("busy_reset_done_count", ndone, 0);
        chk("busy_reset_nonzero_y", nonzero_y0(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
